// File: rtl/goertzel_multi.sv
// goertzel_multi: time-multiplexed multi-bin Goertzel filter bank; define GOERTZEL_SATURATE_EN to saturate s0 instead of wrapping
module goertzel_multi #(
    parameter int SAMPLE_W = 16,
    parameter int ACC_W    = 32,
    parameter int COEF_W   = 18,
    parameter int NBINS    = 4,
    parameter int N        = 1000,
    parameter int POWER_W  = 64,
    localparam int BW      = NBINS > 1 ? $clog2(NBINS) : 1
) (
    input  logic                clock,
    input  logic                reset_n,
    input  logic                sample_valid,
    input  logic [SAMPLE_W-1:0] sample,
    input  logic                coef_we,
    input  logic [BW-1:0]       coef_addr,
    input  logic [COEF_W-1:0]   coef_data,
    output logic                busy,
    output logic                power_valid,
    output logic [BW-1:0]       power_bin,
    output logic [POWER_W-1:0]  power,
    output logic                overrun
);
    localparam int FRAC = COEF_W - 2;
    localparam int UW   = ACC_W + COEF_W + 2;
    localparam int PW   = 2 * ACC_W + COEF_W + 2;
    localparam int PX   = PW > POWER_W ? PW : POWER_W;
`ifdef GOERTZEL_SATURATE_EN
    localparam logic signed [UW-1:0] SMAX = {{(UW-ACC_W+1){1'b0}}, {(ACC_W-1){1'b1}}};
    localparam logic signed [UW-1:0] SMIN = {{(UW-ACC_W+1){1'b1}}, {(ACC_W-1){1'b0}}};
`endif
    typedef enum logic [1:0] {IDLE, UPDATE, POWER} state_t;
    state_t state, state_nx;
    logic [BW-1:0] bin;
    logic [15:0] count;
    logic [SAMPLE_W-1:0] samp;
    logic [COEF_W-1:0] coef [0:(1<<BW)-1];
    logic [ACC_W-1:0] s1 [0:(1<<BW)-1];
    logic [ACC_W-1:0] s2 [0:(1<<BW)-1];
    logic last_bin, last_sample;
    logic signed [UW-1:0] prod, s0w;
    logic [ACC_W-1:0] s0;
    logic signed [PX-1:0] p1, p2, pc, pterm;

    // state register
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else state <= state_nx;
    end

    // next-state logic and status
    always_comb begin
        state_nx = state;
        last_bin = bin == BW'(NBINS - 1);
        last_sample = count == 16'(N - 1);
        busy = state != IDLE;
        case (state)
            IDLE:    state_nx = sample_valid ? UPDATE : IDLE;
            UPDATE:  state_nx = last_bin ? (last_sample ? POWER : IDLE) : UPDATE;
            POWER:   state_nx = last_bin ? IDLE : POWER;
            default: state_nx = IDLE;
        endcase
    end

    // recurrence and power arithmetic for the bin currently selected
    always_comb begin
        prod = UW'($signed(coef[bin])) * UW'($signed(s1[bin]));
        s0w = UW'($signed(samp)) + (prod >>> FRAC) - UW'($signed(s2[bin]));
`ifdef GOERTZEL_SATURATE_EN
        s0 = s0w > SMAX ? SMAX[ACC_W-1:0] : (s0w < SMIN ? SMIN[ACC_W-1:0] : s0w[ACC_W-1:0]);
`else
        s0 = s0w[ACC_W-1:0];
`endif
        p1 = PX'($signed(s1[bin]));
        p2 = PX'($signed(s2[bin]));
        pc = PX'($signed(coef[bin]));
        pterm = p1 * p1 + p2 * p2 - ((pc * p1 * p2) >>> FRAC);
    end

    // per-bin state, coefficient store, sample latch and output registers
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            bin <= '0;
            count <= '0;
            samp <= '0;
            power_valid <= 1'b0;
            power_bin <= '0;
            power <= '0;
            overrun <= 1'b0;
            for (int i = 0; i < (1 << BW); i++) begin
                coef[i] <= '0;
                s1[i] <= '0;
                s2[i] <= '0;
            end
        end else begin
            power_valid <= 1'b0;
            if (coef_we) coef[coef_addr] <= coef_data;
            if (sample_valid && state != IDLE) overrun <= 1'b1;
            case (state)
                IDLE: if (sample_valid) begin
                    samp <= sample;
                    bin <= '0;
                end
                UPDATE: begin
                    s2[bin] <= s1[bin];
                    s1[bin] <= s0;
                    bin <= last_bin ? '0 : bin + BW'(1);
                    if (last_bin && !last_sample) count <= count + 16'd1;
                end
                POWER: begin
                    power_valid <= 1'b1;
                    power_bin <= bin;
                    power <= pterm[PX-1] ? '0 : pterm[POWER_W-1:0];
                    s1[bin] <= '0;
                    s2[bin] <= '0;
                    bin <= last_bin ? '0 : bin + BW'(1);
                    if (last_bin) count <= '0;
                end
                default: bin <= '0;
            endcase
        end
    end
endmodule
